// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32I pipeline front end.
//   NOP_INSTR         : canonical bubble instruction (addi x0, x0, 0)
//   RESET_PC_DEFAULT  : default reset fetch address
//   if_id_t           : IF/ID pipeline register contents
// Optional feature macro: FETCH_MISALIGN_EN adds the misalign field to if_id_t.
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
`ifdef FETCH_MISALIGN_EN
        logic        misalign;
`endif
    } if_id_t;

    // Entry loaded while reset is asserted.
    function automatic if_id_t if_id_reset_entry();
        if_id_t e;
        e.valid    = 1'b0;
        e.pc       = 32'h0000_0000;
        e.pc4      = 32'h0000_0000;
        e.instr    = NOP_INSTR;
`ifdef FETCH_MISALIGN_EN
        e.misalign = 1'b0;
`endif
        return e;
    endfunction

    // Turns a would-be capture into a bubble; pc/pc4 are kept for debug visibility.
    function automatic if_id_t if_id_bubble(if_id_t src);
        if_id_t e;
        e          = src;
        e.valid    = 1'b0;
        e.instr    = NOP_INSTR;
`ifdef FETCH_MISALIGN_EN
        e.misalign = 1'b0;
`endif
        return e;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory bus between the fetch stage and a combinational IMEM.
//   imem_addr  : word address [31:2] driven by fetch
//   imem_instr : instruction word returned combinationally by the memory
// Modports: master (fetch side), slave (memory side).
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic [29:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (output imem_addr, input  imem_instr);
    modport slave  (input  imem_addr, output imem_instr);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Generic pipeline register holding an if_id_t entry.
// Priority: flush > stall > capture.
//   clk, rst_n : clock, asynchronous active-low reset
//   stall      : hold current contents
//   flush      : write a bubble built from d (valid=0, NOP)
//   d          : entry to capture
//   q          : registered entry
// Optional feature macro: FETCH_MISALIGN_EN (misalign field cleared on flush).
// ---------------------------------------------------------------------------
module if_id_reg
    import rv32_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // IF -> ID stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= if_id_reset_entry();
        end else if (flush) begin
            q <= if_id_bubble(d);
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// RV32I instruction fetch: PC register, next-PC mux, IMEM range check and
// the IF/ID pipeline register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem              : IMEM bus (master), imem_addr = pc_q[31:2]
//   stall_i           : hold PC and IF/ID
//   flush_i           : invalidate the IF/ID entry being written
//   redirect_i        : load PC from redirect_pc_i (also flushes IF/ID)
//   redirect_pc_i     : redirect byte address
//   pc_o              : current fetch PC
//   if_id_valid_o/pc_o/pc4_o/instr_o : IF/ID entry
//   if_id_misalign_o  : misaligned redirect target marker (FETCH_MISALIGN_EN only)
// Optional feature macro: FETCH_MISALIGN_EN.
// ---------------------------------------------------------------------------
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_stage_if.master      imem,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic [31:0]        pc_o,
    output logic               if_id_valid_o,
    output logic [31:0]        if_id_pc_o,
    output logic [31:0]        if_id_pc4_o,
    output logic [31:0]        if_id_instr_o
`ifdef FETCH_MISALIGN_EN
    ,
    output logic               if_id_misalign_o
`endif
);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic        in_range;
    logic        kill;
    if_id_t      capture;
    if_id_t      entry;

    assign pc_plus4      = pc_q + 32'd4;
    assign imem.imem_addr = pc_q[31:2];
    assign pc_o          = pc_q;
    assign in_range      = (32'(pc_q[31:2]) < 32'(IMEM_DEPTH));
    assign kill          = flush_i | redirect_i;

    // Fetch PC stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[31:2], 2'b00};
        end else if (!stall_i) begin
            pc_q <= pc_plus4;
        end
    end

`ifdef FETCH_MISALIGN_EN
    // The unaligned target is remembered until the aligned PC is captured,
    // so ID sees the original address for the trap.
    logic        mis_pending;
    logic [31:0] mis_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_pending <= 1'b0;
            mis_pc      <= 32'h0000_0000;
        end else if (redirect_i) begin
            mis_pending <= |redirect_pc_i[1:0];
            mis_pc      <= redirect_pc_i;
        end else if (flush_i || !stall_i) begin
            mis_pending <= 1'b0;
        end
    end

    always_comb begin
        capture.valid    = in_range;
        capture.pc       = pc_q;
        capture.pc4      = pc_plus4;
        capture.instr    = in_range ? imem.imem_instr : NOP_INSTR;
        capture.misalign = 1'b0;
        if (mis_pending && !kill) begin
            capture.valid    = 1'b1;
            capture.pc       = mis_pc;
            capture.instr    = NOP_INSTR;
            capture.misalign = 1'b1;
        end
    end

    assign if_id_misalign_o = entry.misalign;
`else
    // Target byte-offset bits have no meaning without the misalign feature.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        capture.valid = in_range;
        capture.pc    = pc_q;
        capture.pc4   = pc_plus4;
        capture.instr = in_range ? imem.imem_instr : NOP_INSTR;
    end
`endif

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall_i),
        .flush (kill),
        .d     (capture),
        .q     (entry)
    );

    assign if_id_valid_o = entry.valid;
    assign if_id_pc_o    = entry.pc;
    assign if_id_pc4_o   = entry.pc4;
    assign if_id_instr_o = entry.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with a combinational IMEM model
// (word i = 32'hC0DE_0000 | i for i < 256; other addresses return junk).
// Optional feature macro: FETCH_MISALIGN_EN.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
    import rv32_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
`ifdef FETCH_MISALIGN_EN
    logic        if_id_misalign_o;
`endif

    int n_checks;
    int n_pass;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (256)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem_bus),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .if_id_valid_o (if_id_valid_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_instr_o (if_id_instr_o)
`ifdef FETCH_MISALIGN_EN
        ,
        .if_id_misalign_o (if_id_misalign_o)
`endif
    );

    function automatic logic [31:0] word(int unsigned idx);
        logic [31:0] w;
        w = 32'hC0DE_0000 | (idx & 32'h0000_FFFF);
        return w;
    endfunction

    assign imem_bus.imem_instr = (imem_bus.imem_addr < 30'd256)
                                 ? word(32'(imem_bus.imem_addr)) : 32'hBAD0_BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag, input logic valid,
                               input logic [31:0] pc, input logic [31:0] pc4,
                               input logic [31:0] instr);
        check({tag, ".valid"}, 32'(if_id_valid_o), 32'(valid));
        check({tag, ".pc"},    if_id_pc_o,  pc);
        check({tag, ".pc4"},   if_id_pc4_o, pc4);
        check({tag, ".instr"}, if_id_instr_o, instr);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;

        // Asynchronous reset visible before any clock edge.
        #3;
        check("rst_pc_async", pc_o, 32'h0);
        repeat (2) step();
        check("rst_pc", pc_o, 32'h0);
        check("rst_imem_addr", 32'(imem_bus.imem_addr), 32'h0);
        check_entry("rst", 1'b0, 32'h0, 32'h0, NOP_INSTR);
`ifdef FETCH_MISALIGN_EN
        check("rst_misalign", 32'(if_id_misalign_o), 32'h0);
`endif
        rst_n = 1'b1;

        // Sequential fetch
        step();
        check_entry("seq0", 1'b1, 32'h0, 32'h4, word(0));
        check("seq0_pc", pc_o, 32'h4);
        step();
        check_entry("seq1", 1'b1, 32'h4, 32'h8, word(1));
        check("seq1_pc", pc_o, 32'h8);

        // Stall two cycles at PC 0x8
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_pc", pc_o, 32'h8);
            check_entry("stall", 1'b1, 32'h4, 32'h8, word(1));
        end
        stall_i = 1'b0;
        step();
        check_entry("post_stall", 1'b1, 32'h8, 32'hC, word(2));
        check("post_stall_pc", pc_o, 32'hC);
        step();
        check_entry("post_stall2", 1'b1, 32'hC, 32'h10, word(3));

        // Redirect to 0x40
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        check("redir_pc", pc_o, 32'h40);
        check_entry("redir_n1", 1'b0, 32'h10, 32'h14, NOP_INSTR);
        step();
        check_entry("redir_n2", 1'b1, 32'h40, 32'h44, word(16));
        check("redir_n2_pc", pc_o, 32'h44);

        // Redirect and stall together: redirect wins
        redirect_i    = 1'b1;
        stall_i       = 1'b1;
        redirect_pc_i = 32'h80;
        step();
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        check("rs_pc", pc_o, 32'h80);
        check_entry("rs_n1", 1'b0, 32'h44, 32'h48, NOP_INSTR);
        step();
        check_entry("rs_n2", 1'b1, 32'h80, 32'h84, word(32));

        // Stall and flush without redirect: flush IF/ID, PC holds
        stall_i = 1'b1;
        flush_i = 1'b1;
        step();
        stall_i = 1'b0;
        flush_i = 1'b0;
        check("sf_pc", pc_o, 32'h84);
        check_entry("sf_n1", 1'b0, 32'h84, 32'h88, NOP_INSTR);
        step();
        check_entry("sf_n2", 1'b1, 32'h84, 32'h88, word(33));

        // Out-of-range fetch at 0x400
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h3FC;
        step();
        redirect_i = 1'b0;
        step();
        check_entry("last_word", 1'b1, 32'h3FC, 32'h400, word(255));
        check("oor_addr", 32'(imem_bus.imem_addr), 32'h100);
        step();
        check_entry("oor", 1'b0, 32'h400, 32'h404, NOP_INSTR);
        check("oor_pc", pc_o, 32'h404);

        // PC wrap at the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        check("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc_o, 32'h0);
        check_entry("wrap_top", 1'b0, 32'hFFFF_FFFC, 32'h0, NOP_INSTR);
        step();
        check_entry("wrap_zero", 1'b1, 32'h0, 32'h4, word(0));

        // Unaligned redirect target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h22;
        step();
        redirect_i = 1'b0;
        check("mis_pc", pc_o, 32'h20);
`ifdef FETCH_MISALIGN_EN
        step();
        check("mis_flag", 32'(if_id_misalign_o), 32'h1);
        check("mis_valid", 32'(if_id_valid_o), 32'h1);
        check("mis_entry_pc", if_id_pc_o, 32'h22);
        check("mis_instr", if_id_instr_o, NOP_INSTR);
        step();
        check("mis_clear", 32'(if_id_misalign_o), 32'h0);
        check_entry("mis_after", 1'b1, 32'h24, 32'h28, word(9));
`else
        step();
        check_entry("mis_drop", 1'b1, 32'h20, 32'h24, word(8));
`endif

        // Reset asserted mid-operation takes effect without a clock edge
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc_o, 32'h0);
        check_entry("midrst", 1'b0, 32'h0, 32'h0, NOP_INSTR);
        #1;
        rst_n = 1'b1;
        step();
        check_entry("restart", 1'b1, 32'h0, 32'h4, word(0));
        check("restart_pc", pc_o, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
